// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the single-cycle MIPS CPU: instruction and data RAMs plus a
// boot loader that streams the program into instruction RAM before releasing the CPU.
module cpu_mem_responder #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_addr,
    output logic [31:0] i_datain,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_dataout,
    input  logic        d_we,
    input  logic        d_re,
    output logic [31:0] d_datain,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        start,
    output logic        addr_err
);
    localparam int unsigned IW = $clog2(IMEM_DEPTH);
    localparam int unsigned DW = $clog2(DMEM_DEPTH);

    typedef enum logic {StLoad, StRun} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ld_ptr_q, ld_ptr_d;
    logic [31:0]   i_data_q, d_data_q;
    logic          err_q, err_d;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    logic          run, ld_accept;
    logic [IW-1:0] i_idx;
    logic          i_oor, i_mis;
    logic [DW-1:0] d_idx;
    logic          d_oor, d_mis;

    assign run       = (state_q == StRun);
    assign ld_ready  = (state_q == StLoad);
    assign start     = run;
    assign ld_accept = ld_valid && ld_ready;

    // Word index from the byte address; any set bit above the index is out of range.
    assign i_idx = i_addr[IW+1:2];
    assign i_oor = |i_addr[31:IW+2];
    assign i_mis = |i_addr[1:0];
    assign d_idx = d_addr[DW+1:2];
    assign d_oor = |d_addr[31:DW+2];
    assign d_mis = |d_addr[1:0];

    assign i_datain = i_data_q;
    assign d_datain = d_data_q;
    assign addr_err = err_q;

    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        err_d    = err_q;
        unique case (state_q)
            StLoad: begin
                if (ld_accept) begin
                    // The last RAM slot ends the load even without ld_last; the pointer never wraps.
                    if (ld_last || ld_ptr_q == IW'(IMEM_DEPTH - 1)) begin
                        state_d = StRun;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (i_oor || i_mis) begin
                    err_d = 1'b1;
                end
                if ((d_we || d_re) && (d_oor || d_mis)) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StLoad;
            ld_ptr_q <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_ptr_q <= ld_ptr_d;
            err_q    <= err_d;
            if (run) begin
                i_data_q <= i_oor ? '0 : imem[i_idx];
                if (d_re) begin
                    d_data_q <= d_oor ? '0 : (d_we ? d_dataout : dmem[d_idx]);
                end
            end
        end
    end

    // RAM arrays carry no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (!reset && ld_accept) begin
            imem[ld_ptr_q] <= ld_data;
        end
        if (!reset && run && d_we && !d_oor) begin
            dmem[d_idx] <= d_dataout;
        end
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the single-cycle MIPS CPU.
- Serves the CPU instruction port (i_datain) from an internal instruction RAM and the data port (d_addr/d_dataout to d_datain) from an internal data RAM.
- Owns a boot loader FSM that fills instruction RAM over a valid/ready stream, then raises start to release the CPU.
- Sits between the CPU core and the top-level or bench program loader.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit instruction words (power of 2, ≥4).
- DMEM_DEPTH, 64, number of 32-bit data words (power of 2, ≥4).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_addr  in  32  CPU pc, byte address.
- i_datain  out  32  instruction word to the CPU.
- d_addr  in  32  CPU data byte address.
- d_dataout  in  32  CPU store data.
- d_we  in  1  CPU store strobe.
- d_re  in  1  CPU load strobe.
- d_datain  out  32  load data to the CPU.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  marks the final loader word; qualified by ld_valid.
- ld_ready  out  1  responder accepts a loader word.
- start  out  1  CPU run enable.
- addr_err  out  1  sticky flag: out-of-range or misaligned access.

Behaviour:
- Reset (async, immediate): state=LOAD, ld_ptr=0, ld_ready=1, start=0, i_datain=0, d_datain=0, addr_err=0. RAM contents are not cleared.
- FSM states:
  - LOAD: a word is accepted when ld_valid&&ld_ready. On acceptance, imem[ld_ptr] is written with ld_data and ld_ptr increments.
  - LOAD to RUN: taken on the cycle after acceptance of a word with ld_last=1, or of the word at ld_ptr==IMEM_DEPTH-1 (forced end; ld_ptr never wraps). In that cycle the registers update to ld_ready=0 and start=1.
  - RUN: terminal state. ld_valid is ignored and ld_ready stays 0. Leaving RUN requires reset.
- ld_valid with ld_ready=0 has no effect and no error.
- In LOAD, i_datain=0 (NOP), d_datain holds 0, and d_we/d_re are ignored.
- Instruction port (RUN):
  - Registered read, 1-cycle latency: i_datain(t+1) = imem[i_addr[log2(IMEM_DEPTH)+1:2]] at t.
  - Index ≥ IMEM_DEPTH (upper bits nonzero): i_datain=0 and addr_err set.
  - i_addr[1:0]≠0: addr_err set; the low bits are ignored for indexing.
- Data port (RUN), index = d_addr[log2(DMEM_DEPTH)+1:2]:
  - d_we: dmem[index] is written with d_dataout at the edge.
  - d_re: d_datain is updated at the edge with dmem[index], 1-cycle latency.
  - d_we&&d_re on the same index: write-first, so d_datain returns the new d_dataout.
  - d_re low: d_datain holds its previous value.
  - Out-of-range store: dropped, addr_err set.
  - Out-of-range load: d_datain=0, addr_err set.
  - Misaligned address: addr_err set; the access proceeds with the low bits ignored.
- addr_err: sticky; cleared only by reset.
- Reset mid-load: returns to LOAD with ld_ptr=0. Already-written words are retained but will be overwritten by the reload.
- Reset during RUN: start drops asynchronously; pending writes of that edge are not performed.

Test Plan:
- Boot: reset, then stream 3 words {0x8C010001, 0x8C020002, 0x00221820}, the last with ld_last=1 → ld_ready falls and start rises the cycle after the 3rd accept. Then i_addr=0x4 → i_datain=0x8C020002 one cycle later.
- Backpressure and forced end: with ld_valid held continuously and ld_last never set, all IMEM_DEPTH words load → start=1 after word 63. ld_valid afterwards leaves imem[0] unchanged.
- Data RAM: d_we at d_addr=0x3C with data 0x000000AB, then d_re at 0x3C → d_datain=0x000000AB on the next cycle. With d_re low, d_datain holds 0x000000AB.
- Write-first: d_we=1 and d_re=1 at 0x8 with d_dataout=0x00003C00 and old content 0x11 → d_datain=0x00003C00.
- Errors:
  - d_addr=0x400 store: dropped, addr_err=1.
  - i_addr=0x2: addr_err=1 and i_datain=imem[0].
  - addr_err remains 1 through later legal accesses until reset.
- Reset mid-load after 2 words → ld_ptr restarts at 0, start stays 0, and a new 1-word load with ld_last reaches RUN.
